// File: rtl/logical_tile_clb_fle_frac.sv
// Fracturable logic element: K-input LUT (or two (K-1)-input halves), two
// optionally registered outputs, and a serial configuration chain with load tracking.
module logical_tile_clb_fle_frac #(
  parameter int K     = 4,
  parameter int CFG_W = 2**K + 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         prog_en,
  input  logic         ccff_head,
  output logic         ccff_tail,
  input  logic [K-1:0] fle_in,
  input  logic         fle_ce,
  input  logic         fle_set,
  input  logic         fle_clr,
  output logic [1:0]   fle_out,
  output logic         cfg_valid
);

  localparam int CNT_W = $clog2(CFG_W + 1);

  logic [CFG_W-1:0]  cfg;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        ff_q;
  logic              prog_en_d;
  logic              valid;

  logic              frac_mode;
  logic [1:0]        out_reg;
  logic [1:0]        ff_init;
  logic [2**K-1:0]   mask;
  logic [K-2:0]      addr_lo;
  logic [1:0]        comb;
  logic              load_done;

  assign frac_mode = cfg[CFG_W-1];
  assign out_reg   = cfg[CFG_W-2 -: 2];
  assign ff_init   = cfg[CFG_W-4 -: 2];
  assign mask      = cfg[2**K-1:0];
  assign addr_lo   = fle_in[K-2:0];

  // In fractured mode each output reads its own half of the mask; the top input is unused.
  always_comb begin
    comb = '0;
    if (frac_mode) begin
      comb[0] = mask[{1'b0, addr_lo}];
      comb[1] = mask[{1'b1, addr_lo}];
    end else begin
      comb[0] = mask[fle_in];
      comb[1] = mask[fle_in];
    end
  end

  // A load is accepted only when the burst just ended and delivered at least CFG_W bits.
  assign load_done = !prog_en && prog_en_d && (cnt == CNT_W'(CFG_W));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg       <= '0;
      cnt       <= '0;
      prog_en_d <= 1'b0;
      valid     <= 1'b0;
    end else begin
      prog_en_d <= prog_en;
      if (prog_en) begin
        cfg   <= {cfg[CFG_W-2:0], ccff_head};
        valid <= 1'b0;
        if (!prog_en_d)
          cnt <= CNT_W'(1);
        else if (cnt != CNT_W'(CFG_W))
          cnt <= cnt + 1'b1;
      end else if (load_done) begin
        valid <= 1'b1;
      end
    end
  end

  // User FFs freeze while configuration is shifting; init values win on the load edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ff_q <= '0;
    end else if (load_done) begin
      ff_q <= ff_init;
    end else if (valid && fle_ce && !prog_en) begin
      for (int i = 0; i < 2; i++) begin
        if (fle_clr)
          ff_q[i] <= 1'b0;
        else if (fle_set)
          ff_q[i] <= 1'b1;
        else
          ff_q[i] <= comb[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_out
      assign fle_out[gi] = valid ? (out_reg[gi] ? ff_q[gi] : comb[gi]) : 1'b0;
    end
  endgenerate

  assign ccff_tail = cfg[CFG_W-1];
  assign cfg_valid = valid;

endmodule

// File: tb/tb_logical_tile_clb_fle_frac.sv
// Randomised + directed bench for the fracturable FLE, scoreboarded against a
// burst-length based reference model.
module tb_logical_tile_clb_fle_frac;
  localparam int K     = 4;
  localparam int CFG_W = 2**K + 5;
  localparam int HALF  = 2**(K-1);

  logic         clk = 1'b0;
  logic         reset, prog_en, ccff_head, fle_ce, fle_set, fle_clr;
  logic [K-1:0] fle_in;
  logic         ccff_tail, cfg_valid;
  logic [1:0]   fle_out;

  logical_tile_clb_fle_frac #(.K(K)) dut (
    .clk(clk), .reset(reset), .prog_en(prog_en), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .fle_in(fle_in), .fle_ce(fle_ce), .fle_set(fle_set),
    .fle_clr(fle_clr), .fle_out(fle_out), .cfg_valid(cfg_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] out;
    logic       tail;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   txn        = 0;

  // Reference model: configuration word, length of the current shift burst, user FF values.
  logic [CFG_W-1:0] m_cfg   = '0;
  int               m_burst = 0;
  logic             m_prev  = 1'b0;
  logic             m_valid = 1'b0;
  logic [1:0]       m_ff    = '0;

  function automatic logic lut(input int i, input logic [K-1:0] a);
    int idx;
    if (m_cfg[CFG_W-1]) idx = (int'(a) % HALF) + ((i == 1) ? HALF : 0);
    else                idx = int'(a);
    return m_cfg[idx];
  endfunction

  function automatic logic [1:0] model_out();
    logic [1:0] o;
    for (int i = 0; i < 2; i++)
      o[i] = !m_valid ? 1'b0 : (m_cfg[CFG_W-3+i] ? m_ff[i] : lut(i, fle_in));
    return o;
  endfunction

  task automatic model_edge();
    logic [1:0] nf;
    if (!reset) begin
      m_cfg = '0; m_burst = 0; m_prev = 1'b0; m_valid = 1'b0; m_ff = '0;
    end else begin
      nf = m_ff;
      if (prog_en) begin
        m_burst = m_prev ? m_burst + 1 : 1;
        m_cfg   = {m_cfg[CFG_W-2:0], ccff_head};
        m_valid = 1'b0;
      end else if (m_prev && m_burst >= CFG_W) begin
        m_valid = 1'b1;
        nf = {m_cfg[CFG_W-4], m_cfg[CFG_W-5]};
      end else if (m_valid && fle_ce) begin
        for (int i = 0; i < 2; i++)
          nf[i] = fle_clr ? 1'b0 : (fle_set ? 1'b1 : lut(i, fle_in));
      end
      m_ff   = nf;
      m_prev = prog_en;
    end
  endtask

  // Inputs are stable from just after a rising edge; the expected view is queued then.
  task automatic cycle();
    exp_t e;
    e.out   = model_out();
    e.tail  = m_cfg[CFG_W-1];
    e.valid = m_valid;
    sb.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load(input logic [63:0] word, input int n);
    prog_en = 1'b1;
    for (int b = n - 1; b >= 0; b--) begin
      ccff_head = word[b];
      cycle();
    end
    prog_en   = 1'b0;
    ccff_head = 1'b0;
    cycle();
  endtask

  function automatic logic [63:0] mkcfg(input logic frac, input logic [1:0] oreg,
                                        input logic [1:0] init, input logic [15:0] msk);
    return 64'({frac, oreg, init, msk});
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      txn++;
      $display("txn %0d: fle_out=%b ccff_tail=%b cfg_valid=%b", txn, fle_out, ccff_tail, cfg_valid);
      compared++;
      if (fle_out !== e.out) begin
        mismatched++;
        $display("FAIL fle_out txn %0d: got %b want %b", txn, fle_out, e.out);
      end
      compared++;
      if (ccff_tail !== e.tail) begin
        mismatched++;
        $display("FAIL ccff_tail txn %0d: got %b want %b", txn, ccff_tail, e.tail);
      end
      compared++;
      if (cfg_valid !== e.valid) begin
        mismatched++;
        $display("FAIL cfg_valid txn %0d: got %b want %b", txn, cfg_valid, e.valid);
      end
    end
  end

  initial begin
    logic [63:0] w;
    int          len;
    reset = 1'b0; prog_en = 1'b0; ccff_head = 1'b0;
    fle_in = '0; fle_ce = 1'b0; fle_set = 1'b0; fle_clr = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    cycle();
    reset = 1'b1;
    cycle();

    // Reset in the middle of a load discards it
    prog_en = 1'b1;
    for (int b = 0; b < 10; b++) begin
      ccff_head = 1'($urandom);
      cycle();
    end
    reset = 1'b0; prog_en = 1'b0;
    cycle();
    reset = 1'b1;
    cycle(); cycle();

    // AND4, combinational outputs
    load(mkcfg(1'b0, 2'b00, 2'b00, 16'h8000), CFG_W);
    fle_in = 4'hF; cycle();
    fle_in = 4'hE; cycle();

    // Fractured, out0 registered, init 01
    load(mkcfg(1'b1, 2'b01, 2'b01, 16'h6996), CFG_W);
    fle_ce = 1'b1; fle_in = 4'b0001; cycle(); cycle();
    fle_in = 4'b0011; cycle(); cycle();

    // FF controls with both outputs registered
    load(mkcfg(1'b0, 2'b11, 2'b00, 16'($urandom)), CFG_W);
    fle_set = 1'b1; fle_clr = 1'b1; cycle(); cycle();
    fle_clr = 1'b0; cycle(); cycle();
    fle_ce = 1'b0; fle_set = 1'b0; fle_clr = 1'b1; cycle(); cycle();
    fle_clr = 1'b0;

    // Short load, then a double-length chained load
    load(64'($urandom), CFG_W - 1);
    cycle();
    w = {$urandom, $urandom};
    load(w, 2 * CFG_W);
    fle_in = 4'($urandom); cycle();

    // Reload while active
    prog_en = 1'b1; ccff_head = 1'b1; cycle();
    load(mkcfg(1'b1, 2'b10, 2'b11, 16'($urandom)), CFG_W);

    // Randomised loads and user traffic
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0:       len = CFG_W - 1 - int'($urandom_range(0, 5));
        1:       len = CFG_W + int'($urandom_range(1, 20));
        default: len = CFG_W;
      endcase
      w = {$urandom, $urandom};
      load(w, len);
      for (int c = 0; c < 12; c++) begin
        fle_in  = 4'($urandom);
        fle_ce  = ($urandom_range(0, 3) != 0);
        fle_set = ($urandom_range(0, 4) == 0);
        fle_clr = ($urandom_range(0, 4) == 0);
        reset   = ($urandom_range(0, 60) != 0);
        prog_en = ($urandom_range(0, 30) == 0);
        ccff_head = 1'($urandom);
        cycle();
      end
      reset = 1'b1; prog_en = 1'b0; fle_set = 1'b0; fle_clr = 1'b0;
      cycle();
    end

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
